// File: rtl/keyed_mux_lock_array_pkg.sv
// lock_pkg: shared FSM states, key sizing and selector width for keyed_mux_lock_array
// Contents: state_t (IDLE/SHIFT/ACTIVE), SEL_W (key bits per MUX), key_width() (total key bits)
package lock_pkg;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, ACTIVE} state_t;
  function automatic int key_width(input int num_mux);
    return num_mux * SEL_W;
  endfunction
endpackage

// File: rtl/keyed_mux_lock_array_key_mux4.sv
// key_mux4: single 4:1 key-controlled selector
// Ports: cand[3:0] candidates, sel[1:0] key-derived select, o selected candidate
module key_mux4 (
  input  logic [3:0] cand,
  input  logic [1:0] sel,
  output logic       o
);
  assign o = cand[sel];
endmodule

// File: rtl/keyed_mux_lock_array.sv
// keyed_mux_lock_array: serially keyed array of registered 4:1 MUX locks with safe-value gating
// Ports: clk, rst_n (async, active-low); key_bit/key_valid/key_ready serial key handshake;
//        key_clear drops the key; cand[4*NUM_MUX-1:0] candidates; mux_o registered outputs;
//        locked high unless ACTIVE; key_done one-cycle pulse on entry to ACTIVE
module keyed_mux_lock_array
  import lock_pkg::*;
#(
  parameter int NUM_MUX  = 5,
  parameter int SEL_W    = 2,
  parameter bit SAFE_VAL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_bit,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic                   key_clear,
  input  logic [4*NUM_MUX-1:0]   cand,
  output logic [NUM_MUX-1:0]     mux_o,
  output logic                   locked,
  output logic                   key_done
);
  localparam int KEY_W = key_width(NUM_MUX);
  localparam int CNT_W = $clog2(KEY_W + 1);
  state_t             state;
  logic [KEY_W-1:0]   key_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic [NUM_MUX-1:0] sel_o;
  logic               accept;
  logic               last;
  assign key_ready = state != ACTIVE;
  assign locked    = state != ACTIVE;
  // clear wins over a simultaneous valid bit
  assign accept    = key_valid && key_ready && !key_clear;
  assign last      = bit_cnt == CNT_W'(KEY_W - 1);
  for (genvar i = 0; i < NUM_MUX; i++) begin : g_mux
    key_mux4 u_mux (
      .cand(cand[4*i +: 4]),
      .sel (key_q[SEL_W*i +: SEL_W]),
      .o   (sel_o[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_q    <= '0;
      bit_cnt  <= '0;
      mux_o    <= {NUM_MUX{SAFE_VAL}};
      key_done <= 1'b0;
    end else begin
      key_done <= accept && last;
      // gating on key_clear here keeps key-selected data from leaking the cycle locked rises
      mux_o    <= (state == ACTIVE && !key_clear) ? sel_o : {NUM_MUX{SAFE_VAL}};
      if (key_clear) begin
        state   <= IDLE;
        key_q   <= '0;
        bit_cnt <= '0;
      end else if (accept) begin
        key_q   <= {key_bit, key_q[KEY_W-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
        state   <= last ? ACTIVE : SHIFT;
      end
    end
  end
endmodule

// File: tb/tb_keyed_mux_lock_array.sv
// tb_keyed_mux_lock_array: scoreboard bench for keyed_mux_lock_array with key 0x2E4
module tb_keyed_mux_lock_array;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_bit = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_clear = 1'b0;
  logic [19:0] cand = '0;
  logic [4:0]  mux_o;
  logic        key_ready;
  logic        locked;
  logic        key_done;
  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] mux;
    logic       lk;
    logic       rdy;
    logic       dn;
  } exp_t;
  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          m_act;
  int          m_cnt;
  localparam logic [9:0] KEY = 10'h2E4;
  int          sel_tab [5] = '{0, 1, 2, 3, 2};
  keyed_mux_lock_array #(.NUM_MUX(5), .SEL_W(2), .SAFE_VAL(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_bit  (key_bit),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_clear(key_clear),
    .cand     (cand),
    .mux_o    (mux_o),
    .locked   (locked),
    .key_done (key_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [4:0] pick(input logic [19:0] c);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = c[4*i + sel_tab[i]];
    return r;
  endfunction
  task automatic check(input string name, input logic [4:0] m, input logic lk, input logic rdy, input logic dn);
    checks++;
    if (mux_o === m && locked === lk && key_ready === rdy && key_done === dn) passes++;
    else $display("FAIL %s @cyc %0d: got mux_o=%b locked=%b key_ready=%b key_done=%b, expected mux_o=%b locked=%b key_ready=%b key_done=%b",
                  name, cyc, mux_o, locked, key_ready, key_done, m, lk, rdy, dn);
  endtask
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      check(mon_e.name, mon_e.mux, mon_e.lk, mon_e.rdy, mon_e.dn);
    end
  end
  task automatic step(input logic v, input logic b, input logic clr, input logic [19:0] c, input string name);
    logic [4:0] em;
    logic       dn;
    key_valid = v;
    key_bit   = b;
    key_clear = clr;
    cand      = c;
    em = (m_act && !clr) ? pick(c) : 5'b0;
    dn = 1'b0;
    if (clr) begin
      m_act = 1'b0;
      m_cnt = 0;
    end else if (v && !m_act) begin
      m_cnt++;
      if (m_cnt == 10) begin
        m_act = 1'b1;
        dn    = 1'b1;
      end
    end
    q.push_back('{cyc + 1, name, em, !m_act, !m_act, dn});
    @(posedge clk);
    #1;
  endtask
  task automatic load_key(input bit gap, input string name);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, KEY[k], 1'b0, 20'($urandom), name);
      if (gap) step(1'b0, ~KEY[k], 1'b0, 20'($urandom), name);
    end
  endtask
  task automatic idle(input int n, input string name);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 20'($urandom), name);
  endtask
  task automatic reset_pulse(input string name);
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_clear = 1'b0;
    #1;
    check(name, 5'b0, 1'b1, 1'b1, 1'b0);
    m_act = 1'b0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    m_act = 1'b0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    q.push_back('{cyc, "reset", 5'b0, 1'b1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step(1'b0, 1'b0, 1'b0, '1, "idle_safe");
    load_key(1'b0, "load");
    idle(6, "active");
    repeat (3) step(1'b1, 1'b1, 1'b0, 20'($urandom), "extra_bits");
    step(1'b0, 1'b0, 1'b1, 20'($urandom), "clear_active");
    idle(2, "after_clear");
    load_key(1'b1, "toggle_load");
    idle(4, "toggle_active");
    step(1'b0, 1'b0, 1'b1, 20'($urandom), "clear2");
    for (int k = 0; k < 5; k++) step(1'b1, KEY[k], 1'b0, 20'($urandom), "partial");
    step(1'b1, KEY[5], 1'b1, 20'($urandom), "clr_with_valid");
    load_key(1'b0, "reload");
    idle(3, "reload_active");
    reset_pulse("rst_active");
    idle(3, "post_rst");
    for (int k = 0; k < 4; k++) step(1'b1, KEY[k], 1'b0, 20'($urandom), "partial2");
    reset_pulse("rst_shift");
    load_key(1'b0, "load_after_rst");
    idle(3, "final_active");
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
      checks += q.size();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/keyed_mux_lock_array.md
# keyed_mux_lock_array

Parametrised, key-programmable MUX locking layer for obfuscated netlists. It replaces the fixed 2-bit-key MUX cells with NUM_MUX registered 4:1 key-controlled selectors. A key register is loaded serially through a valid/ready handshake. Outputs stay forced to a safe value until a complete key has been shifted in. The block sits between the combinational core's candidate wires and the gates that consume the locked nets.

## Interface
Parameters:
- NUM_MUX, 5, number of locked nets (≥1)
- SEL_W, 2, key bits per MUX; 2**SEL_W candidates per MUX (fixed at 2 in this generation)
- SAFE_VAL, 0, value driven on every mux_o bit while not ACTIVE (0 or 1)

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_bit  in  1  serial key data, LSB of MUX 0 first
- key_valid  in  1  key_bit is valid this cycle
- key_ready  out  1  block accepts a key bit this cycle
- key_clear  in  1  discard the key and return to IDLE
- cand  in  4*NUM_MUX  candidates; MUX i uses cand[4i+3:4i]
- mux_o  out  NUM_MUX  registered selector outputs
- locked  out  1  1 unless state is ACTIVE
- key_done  out  1  one-cycle pulse on entry to ACTIVE

## Operation
- KEY_W = NUM_MUX*SEL_W. Shift register key_q[KEY_W-1:0]. Counter bit_cnt is clog2(KEY_W+1) bits wide.
- FSM states:
  - IDLE -> SHIFT on the first key_valid. That bit is accepted in IDLE.
  - SHIFT -> ACTIVE when the accepted bit makes bit_cnt reach KEY_W.
  - ACTIVE -> IDLE on key_clear.
  - key_clear in any state forces IDLE, clears key_q and bit_cnt, and has priority over key_valid in the same cycle.
- Accept: key_valid && key_ready. key_ready = 1 in IDLE and SHIFT, 0 in ACTIVE. Extra bits offered in ACTIVE are ignored.
- Shift rule: key_q <= {key_bit, key_q[KEY_W-1:1]}, so the first bit lands in key_q[0] after KEY_W accepts.
- MUX i selection: sel_i = key_q[2i+1:2i]. Next mux_o[i] = cand[4i+sel_i].
- While not ACTIVE, mux_o is SAFE_VAL on every bit. The candidates are ignored.
- Gaps in key_valid during SHIFT are allowed. bit_cnt holds and the FSM stays in SHIFT.
- Reset mid-SHIFT: the key is lost and the block restarts in IDLE. No partial key is ever applied.

## Timing
- Reset values:
  - state IDLE, key_q 0, bit_cnt 0
  - mux_o all SAFE_VAL
  - locked 1, key_ready 1, key_done 0
- Latency from cand to mux_o is 1 cycle in ACTIVE.
- Key load takes KEY_W accepted bits. With continuous valid, the key for NUM_MUX=5 loads in 10 cycles.
  - ACTIVE, locked=0 and key_done are visible the cycle after the final accept.
  - The first key-selected mux_o appears one cycle after that.
- key_clear in ACTIVE: locked=1 next cycle and mux_o=SAFE_VAL next cycle. No cycle leaks key-selected data after locked rises.
- locked, key_ready and key_done are registered or state-decoded only. They have no combinational path from key_valid.

## Structure
- A shared package, lock_pkg, holds:
  - the FSM state enum (IDLE, SHIFT, ACTIVE)
  - a localparam function computing KEY_W
  - the SEL_W constant
- One sub-module, key_mux4: a single 4:1 selector (cand[3:0], sel[1:0] -> o). It is generated NUM_MUX times.
- The top level holds the FSM, the shift register, the counter and the output registers.

## Test plan
- Reset, then drive cand = all ones with no key: mux_o=0, locked=1 and key_ready=1 for 20 cycles.
- NUM_MUX=5, continuous key stream 0x2E4:
  - done=1 pulse 10 cycles after the first accept
  - sel = {2,3,2,1,0} for MUX 4..0
  - mux_o tracks cand[4i+sel_i] with 1-cycle latency under random cand
- Same key with key_valid toggling every other cycle: ACTIVE after 10 accepts (~20 cycles), with the identical selection result.
- Assert key_clear together with key_valid at the 6th bit: state IDLE, bit_cnt 0. A fresh 10-bit load is required.
- Deassert rst_n asynchronously in ACTIVE and mid-SHIFT: outputs take reset values immediately. ACTIVE is not re-entered without a full reload.
- Offer 3 extra bits in ACTIVE: key_ready=0, key_q unchanged, mux_o unchanged.
